expr_vector_sequencer: RTL



---
 rtl/expr_vector_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer: drives LFSR-derived operands into an expression
// instance, samples its 90-bit result after a settle time and folds each
// sample into a 32-bit rotating-XOR signature.
module expr_vector_sequencer #(
  parameter logic [59:0] SEED       = 60'h0_0000_0000_0001,
  parameter int unsigned SETTLE_CYC = 0,
  parameter logic [31:0] SIG_INIT   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        seed_load,
  input  logic [59:0] seed_in,
  input  logic [15:0] num_vec,
  input  logic [89:0] y_in,
  output logic [3:0]  a0,
  output logic [4:0]  a1,
  output logic [5:0]  a2,
  output logic [3:0]  a3,
  output logic [4:0]  a4,
  output logic [5:0]  a5,
  output logic [3:0]  b0,
  output logic [4:0]  b1,
  output logic [5:0]  b2,
  output logic [3:0]  b3,
  output logic [4:0]  b4,
  output logic [5:0]  b5,
  output logic        busy,
  output logic        done,
  output logic [15:0] vec_count,
  output logic [31:0] signature
);

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYC);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StDone} state_e;

  state_e      state_q, state_d;
  logic [59:0] lfsr_q;
  logic [31:0] sig_q;
  logic [15:0] cnt_q;
  logic [15:0] num_q;
  logic [3:0]  settle_q;
  logic [31:0] fold;
  logic        last_vec;

  assign fold     = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
  assign last_vec = (cnt_q + 16'd1) == num_q;

  // State register; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (num_vec == '0) ? StDone : StSettle;
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (settle_q == '0) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (abort) begin
          state_d = StIdle;
        end else if (last_vec) begin
          state_d = StDone;
        end else begin
          state_d = StSettle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state only, so they are glitch-free.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StSettle, StCapture: busy = 1'b1;
      StDone:              done = 1'b1;
      default:             ;
    endcase
  end

  // Datapath: LFSR, signature, vector counter and settle timer.
  // An abort coinciding with CAPTURE suppresses the fold, count and LFSR step.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= SEED;
      sig_q    <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      settle_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Seed first so a simultaneous start runs from the new seed;
          // all-zero would lock the LFSR, so it maps to 1.
          if (seed_load) lfsr_q <= (seed_in == '0) ? 60'h1 : seed_in;
          if (start) begin
            num_q    <= num_vec;
            cnt_q    <= '0;
            sig_q    <= SIG_INIT;
            settle_q <= SettleInit;
          end
        end
        StSettle: begin
          if (settle_q != '0) settle_q <= settle_q - 4'd1;
        end
        StCapture: begin
          if (!abort) begin
            sig_q    <= {sig_q[30:0], sig_q[31]} ^ fold;
            cnt_q    <= cnt_q + 16'd1;
            lfsr_q   <= {lfsr_q[58:0], lfsr_q[59] ^ lfsr_q[58]};
            settle_q <= SettleInit;
          end
        end
        default: ;
      endcase
    end
  end

  assign vec_count = cnt_q;
  assign signature = sig_q;

  assign a0 = lfsr_q[3:0];
  assign a1 = lfsr_q[8:4];
  assign a2 = lfsr_q[14:9];
  assign a3 = lfsr_q[18:15];
  assign a4 = lfsr_q[23:19];
  assign a5 = lfsr_q[29:24];
  assign b0 = lfsr_q[33:30];
  assign b1 = lfsr_q[38:34];
  assign b2 = lfsr_q[44:39];
  assign b3 = lfsr_q[48:45];
  assign b4 = lfsr_q[53:49];
  assign b5 = lfsr_q[59:54];

endmodule
